prog_loader: RTL and testbench

- Hardware counterpart to the simulation dump path. It receives a byte stream over a valid/ready interface and writes 32-bit words into instruction memory and data memory.
- On a start command it raises start_o to release the CPU pipeline.
- It sits between an external host link and the CPU's Instruction_Memory and Data_Memory write ports. It owns the CPU start signal.

---
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses I/D/S frames from a valid/ready link,
// writes 32-bit words into instruction/data memory and releases the CPU on 'S'.
module prog_loader #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    output logic               rx_ready_o,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [31:0]        imem_data_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [31:0]        dmem_data_o,
    output logic               start_o,
    output logic               err_o,
    output logic [15:0]        word_cnt_o
);

    // state   | meaning
    // IDLE    | waiting for a command byte
    // ADDR    | next byte is the start word address
    // COUNT   | next byte is the word count N
    // DATA    | assembling 4*N little-endian data bytes
    // DONE    | CPU released, link closed until reset
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] CMD_I = 8'h49;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_S = 8'h53;

    // The address byte is 8 bits wide, so neither address width may exceed 8.
    localparam int AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;

    logic [2:0]         r_state;
    logic               r_tgt_d;
    logic [AW-1:0]      r_addr;
    logic [7:0]         r_cnt;
    logic [1:0]         r_idx;
    logic [23:0]        r_word;
    logic               r_imem_we;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_data;
    logic               r_dmem_we;
    logic [DMEM_AW-1:0] r_dmem_addr;
    logic [31:0]        r_dmem_data;
    logic               r_start;
    logic               r_err;
    logic [15:0]        r_word_cnt;

    logic               w_accept;
    logic [AW-1:0]      w_addr_in;
    logic [31:0]        w_word;

    assign rx_ready_o = (r_state != S_DONE);
    assign w_accept   = rx_valid_i && rx_ready_o;
    assign w_addr_in  = rx_data_i[AW-1:0];
    assign w_word     = {rx_data_i, r_word};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_tgt_d     <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_imem_we   <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= '0;
            r_dmem_we   <= 1'b0;
            r_dmem_addr <= '0;
            r_dmem_data <= '0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_imem_we <= 1'b0;
            r_dmem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data_i == CMD_I) begin
                            r_tgt_d <= 1'b0;
                            r_state <= S_ADDR;
                        end else if (rx_data_i == CMD_D) begin
                            r_tgt_d <= 1'b1;
                            r_state <= S_ADDR;
                        end else if (rx_data_i == CMD_S) begin
                            r_start <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        r_addr  <= w_addr_in;
                        r_state <= S_COUNT;
                    end
                    S_COUNT: begin
                        r_cnt   <= rx_data_i;
                        r_idx   <= '0;
                        r_state <= (rx_data_i == 8'd0) ? S_IDLE : S_DATA;
                    end
                    S_DATA: begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_word[7:0]   <= rx_data_i;
                            2'd1: r_word[15:8]  <= rx_data_i;
                            2'd2: r_word[23:16] <= rx_data_i;
                            default: begin
                                // Only the low DMEM_AW bits reach dmem, so its
                                // address wraps modulo 2^DMEM_AW for free.
                                if (r_tgt_d) begin
                                    r_dmem_we   <= 1'b1;
                                    r_dmem_addr <= r_addr[DMEM_AW-1:0];
                                    r_dmem_data <= w_word;
                                end else begin
                                    r_imem_we   <= 1'b1;
                                    r_imem_addr <= r_addr[IMEM_AW-1:0];
                                    r_imem_data <= w_word;
                                end
                                if (r_word_cnt != 16'hFFFF) begin
                                    r_word_cnt <= r_word_cnt + 16'd1;
                                end
                                r_addr <= r_addr + 1'b1;
                                r_cnt  <= r_cnt - 8'd1;
                                if (r_cnt == 8'd1) begin
                                    r_state <= S_IDLE;
                                end
                            end
                        endcase
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign imem_we_o   = r_imem_we;
    assign imem_addr_o = r_imem_addr;
    assign imem_data_o = r_imem_data;
    assign dmem_we_o   = r_dmem_we;
    assign dmem_addr_o = r_dmem_addr;
    assign dmem_data_o = r_dmem_data;
    assign start_o     = r_start;
    assign err_o       = r_err;
    assign word_cnt_o  = r_word_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: frames are expanded into
// expected memory writes by a simple model; a monitor checks every strobe.
module tb_prog_loader;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        imem_we_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic        dmem_we_o;
    logic [2:0]  dmem_addr_o;
    logic [31:0] dmem_data_o;
    logic        start_o;
    logic        err_o;
    logic [15:0] word_cnt_o;

    prog_loader #(.IMEM_AW(8), .DMEM_AW(3)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_o (imem_data_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_addr_o (dmem_addr_o),
        .dmem_data_o (dmem_data_o),
        .start_o     (start_o),
        .err_o       (err_o),
        .word_cnt_o  (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          tgt_d;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fixed_q[$];
    wr_t         mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          exp_wc = 0;
    bit          exp_err = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            chk("we_exclusive", {31'd0, imem_we_o & dmem_we_o}, 32'd0);
            if (imem_we_o || dmem_we_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: imem_we=%0b dmem_we=%0b with no write expected (cycle %0d)",
                             imem_we_o, dmem_we_o, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("we_target", {31'd0, dmem_we_o}, {31'd0, mon_e.tgt_d});
                    chk("we_addr", dmem_we_o ? {29'd0, dmem_addr_o} : {24'd0, imem_addr_o}, mon_e.addr);
                    chk("we_data", dmem_we_o ? dmem_data_o : imem_data_o, mon_e.data);
                    chk("we_latency", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        repeat ($urandom_range(0, gapmax)) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
            @(posedge clk_i); #1;
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i); #1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int a, input int n, input int gapmax);
        logic [31:0] w;
        int          span;
        span = (cmd == "D") ? 8 : 256;
        send_byte(cmd, gapmax);
        send_byte(a[7:0], gapmax);
        send_byte(n[7:0], gapmax);
        for (int i = 0; i < n; i++) begin
            w = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom;
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gapmax);
            exp_q.push_back('{tgt_d: (cmd == "D"), addr: (a + i) % span, data: w, cyc: cyc});
        end
        rx_valid_i = 1'b0;
        exp_wc += n;
        if (exp_wc > 65535) exp_wc = 65535;
    endtask

    task automatic idle(input int n);
        rx_valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, rx_ready_o}, 32'd1);
        chk({tag, "_imem_we"}, {31'd0, imem_we_o}, 32'd0);
        chk({tag, "_dmem_we"}, {31'd0, dmem_we_o}, 32'd0);
        chk({tag, "_imem_addr"}, {24'd0, imem_addr_o}, 32'd0);
        chk({tag, "_dmem_addr"}, {29'd0, dmem_addr_o}, 32'd0);
        chk({tag, "_imem_data"}, imem_data_o, 32'd0);
        chk({tag, "_dmem_data"}, dmem_data_o, 32'd0);
        chk({tag, "_start"}, {31'd0, start_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_word_cnt"}, {16'd0, word_cnt_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         n;
        rst_n_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_vals("reset");
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        fixed_q = '{32'h0000_0013, 32'h0005_0820};
        send_frame("I", 0, 2, 0);
        idle(3);
        chk("wc_after_imem", {16'd0, word_cnt_o}, exp_wc);

        fixed_q = '{32'h0000_0005, 32'hAABB_CCDD};
        send_frame("D", 7, 2, 0);
        idle(3);
        chk("err_after_valid", {31'd0, err_o}, 32'd0);
        chk("wc_after_dmem", {16'd0, word_cnt_o}, exp_wc);

        send_frame("I", 8'h10, 0, 0);
        send_frame("I", 8'h10, 1, 0);
        idle(3);

        send_byte(8'h7A, 0);
        rx_valid_i = 1'b0;
        exp_err = 1'b1;
        send_frame("I", $urandom_range(0, 255), 3, 0);
        idle(3);
        chk("err_sticky", {31'd0, err_o}, {31'd0, exp_err});

        fixed_q = '{32'hDEAD_BEEF, 32'h0123_4567};
        send_frame("D", 3, 2, 0);
        fixed_q = '{32'hDEAD_BEEF, 32'h0123_4567};
        send_frame("D", 3, 2, 4);

        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                do b = 8'($urandom); while (b == "I" || b == "D" || b == "S");
                send_byte(b, 2);
                rx_valid_i = 1'b0;
                exp_err = 1'b1;
            end else begin
                n = $urandom_range(0, 6);
                send_frame($urandom_range(0, 1) ? 8'h44 : 8'h49, $urandom_range(0, 255), n,
                           $urandom_range(0, 3));
            end
        end
        idle(4);
        chk("wc_after_random", {16'd0, word_cnt_o}, exp_wc);
        chk("err_after_random", {31'd0, err_o}, {31'd0, exp_err});
        chk("drained_before_reset", exp_q.size(), 32'd0);

        send_byte("I", 0);
        send_byte(8'h20, 0);
        send_byte(8'h03, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        rx_valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_reset_vals("midframe_reset");
        exp_wc  = 0;
        exp_err = 1'b0;
        @(posedge clk_i); #1;
        chk_reset_vals("held_reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        send_frame("I", 5, 2, 2);
        idle(3);
        chk("wc_after_reset", {16'd0, word_cnt_o}, exp_wc);
        chk("start_before_s", {31'd0, start_o}, 32'd0);

        send_byte("S", 0);
        rx_valid_i = 1'b0;
        chk("start_after_s", {31'd0, start_o}, 32'd1);
        chk("ready_in_done", {31'd0, rx_ready_o}, 32'd0);

        rx_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rx_data_i = (k == 0) ? 8'h49 : 8'($urandom);
            @(posedge clk_i); #1;
        end
        rx_valid_i = 1'b0;
        idle(2);
        chk("start_held", {31'd0, start_o}, 32'd1);
        chk("ready_held_low", {31'd0, rx_ready_o}, 32'd0);
        chk("wc_done_ignored", {16'd0, word_cnt_o}, exp_wc);
        chk("pending_writes", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
